// File: rtl/ctrl_defs_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// memory wait-state encoding, the PC register index and the source-match helper.
package ctrl_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [3:0] REG_PC = 4'd15;

  function automatic logic srcMatch(input logic en, input logic [3:0] src,
                                    input logic [3:0] dest);
    return en && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Wait-state sequencer for SRAM accesses in MEM: freezes the pipeline for
// MEM_WAIT cycles per access, then releases it for exactly one cycle.
module mem_wait_fsm #(
  parameter int unsigned MEM_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze,
  output logic mem_busy
);
  import ctrl_defs::*;

  memState_t   state, nextState;
  logic [3:0]  cnt, cntNext;
  logic        freezeRaw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    freezeRaw = 1'b0;
    case (state)
      IDLE: begin
        freezeRaw = mem_req;
        if (mem_req) begin
          if (MEM_WAIT > 1) begin
            cntNext   = 4'(MEM_WAIT - 1);
            nextState = WAIT;
          end else begin
            nextState = DONE;
          end
        end
      end
      WAIT: begin
        freezeRaw = 1'b1;
        cntNext   = cnt - 4'd1;
        if (cnt == 4'd1) nextState = DONE;
      end
      // The request still visible here belongs to the access that is leaving MEM.
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Gated by reset so the pipeline sees no freeze while reset is held.
  assign freeze   = rst & freezeRaw;
  assign mem_busy = (state != IDLE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: RAW detection at ID,
// branch flush gating, SRAM wait-state freeze and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned FWD_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_src_valid,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_req,
  input  logic        branch_taken,
  output logic        hazard,
  output logic        freeze,
  output logic        flush,
  output logic        mem_busy,
  output logic [31:0] stall_cnt
);
  import ctrl_defs::*;

  logic        exeHit, memHit, rawHz;
  logic        freezeInt, flushInt, hazardInt;
  logic [31:0] stallCnt;

  assign exeHit = srcMatch(id_src_valid, id_src1, exe_dest) |
                  srcMatch(id_two_src, id_src2, exe_dest);
  assign memHit = srcMatch(id_src_valid, id_src1, mem_dest) |
                  srcMatch(id_two_src, id_src2, mem_dest);

  // With forwarding only a load in EXE cannot supply its result in time.
  assign rawHz = (FWD_EN != 0) ? (exe_wb_en & exe_mem_read & exeHit)
                               : ((exe_wb_en & exeHit) | (mem_wb_en & memHit));

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) uMemWait (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .freeze   (freezeInt),
    .mem_busy (mem_busy)
  );

  // Priority freeze > flush > hazard; a frozen branch flushes once released.
  assign flushInt  = rst & branch_taken & ~freezeInt;
  assign hazardInt = rst & rawHz & ~flushInt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if ((hazardInt | freezeInt) && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign hazard    = hazardInt;
  assign freeze    = freezeInt;
  assign flush     = flushInt;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three controller instances (forwarding, no forwarding,
// single wait state) share stimulus; expectations are queued then compared.
module tb_pipeline_hazard_ctrl;
  import ctrl_defs::*;

  logic        clk, rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_two_src, id_src_valid, exe_wb_en, exe_mem_read;
  logic        mem_wb_en, mem_req, branch_taken;

  logic        hzA, frzA, flA, busyA;
  logic [31:0] cntOutA;
  logic        hzB, frzB, flB, busyB;
  logic [31:0] cntOutB;
  logic        hzC, frzC, flC, busyC;
  logic [31:0] cntOutC;

  pipeline_hazard_ctrl #(.MEM_WAIT(4), .FWD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_src_valid(id_src_valid), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .hazard(hzA), .freeze(frzA), .flush(flA), .mem_busy(busyA), .stall_cnt(cntOutA));

  pipeline_hazard_ctrl #(.MEM_WAIT(4), .FWD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_src_valid(id_src_valid), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .hazard(hzB), .freeze(frzB), .flush(flB), .mem_busy(busyB), .stall_cnt(cntOutB));

  pipeline_hazard_ctrl #(.MEM_WAIT(1), .FWD_EN(1)) dut_c (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_src_valid(id_src_valid), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .hazard(hzC), .freeze(frzC), .flush(flC), .mem_busy(busyC), .stall_cnt(cntOutC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } expItem_t;

  expItem_t    expQ[$];
  int          nCompared, nMismatched;
  string       curTest;
  logic [31:0] cntA, cntB;
  logic [11:0] patA;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return {31'd0, hzA};
      1: return {31'd0, frzA};
      2: return {31'd0, flA};
      3: return {31'd0, busyA};
      4: return cntOutA;
      5: return {31'd0, hzB};
      6: return cntOutB;
      7: return {31'd0, frzC};
      8: return cntOutC;
      9: return {31'd0, busyC};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushExp(input string name, input int sel, input logic [31:0] exp);
    expItem_t item;
    item.tag = {curTest, ".", name};
    item.sel = sel;
    item.exp = exp;
    expQ.push_back(item);
  endtask

  task automatic drain();
    expItem_t item;
    while (expQ.size() != 0) begin
      item = expQ.pop_front();
      checkVal(item.tag, observe(item.sel), item.exp);
    end
  endtask

  // One cycle of expectations: A outputs, B hazard, C freeze and A/B counters.
  task automatic step(input logic hA, input logic fA, input logic flAx, input logic bA,
                      input logic hB, input logic fC);
    pushExp("hazardA", 0, {31'd0, hA});
    pushExp("freezeA", 1, {31'd0, fA});
    pushExp("flushA", 2, {31'd0, flAx});
    pushExp("busyA", 3, {31'd0, bA});
    pushExp("stallCntA", 4, cntA);
    pushExp("hazardB", 5, {31'd0, hB});
    pushExp("stallCntB", 6, cntB);
    pushExp("freezeC", 7, {31'd0, fC});
    #1;
    drain();
    if ((hA | fA) && (cntA != '1)) cntA = cntA + 32'd1;
    if ((hB | fA) && (cntB != '1)) cntB = cntB + 32'd1;
  endtask

  task automatic clearInputs();
    id_src1 = '0; id_src2 = '0; id_two_src = 1'b0; id_src_valid = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    #2;
    rst = 1'b1;
    cntA = '0;
    cntB = '0;
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    cntA = '0; cntB = '0;
    rst = 1'b0;
    clearInputs();
    patA = 12'b1111_0111_1011;

    // Reset asserted in the middle of a wait sequence
    curTest = "reset";
    doReset();
    @(negedge clk); step(0, 0, 0, 0, 0, 0);
    @(negedge clk); mem_req = 1'b1; step(0, 1, 0, 0, 0, 1);
    @(negedge clk); step(0, 1, 0, 1, 0, 0);
    @(negedge clk);
    exe_dest = 4'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    id_src1 = 4'd4; id_src_valid = 1'b1; branch_taken = 1'b1;
    rst = 1'b0;
    #1;
    pushExp("inRst.freezeA", 1, 32'd0);
    pushExp("inRst.busyA", 3, 32'd0);
    pushExp("inRst.stallCntA", 4, 32'd0);
    pushExp("inRst.hazardA", 0, 32'd0);
    pushExp("inRst.flushA", 2, 32'd0);
    pushExp("inRst.freezeC", 7, 32'd0);
    pushExp("inRst.busyC", 9, 32'd0);
    drain();
    cntA = '0; cntB = '0;
    @(negedge clk); clearInputs(); rst = 1'b1; step(0, 0, 0, 0, 0, 0);
    @(negedge clk); mem_req = 1'b1; step(0, 1, 0, 0, 0, 1);

    // Load-use and general RAW detection
    curTest = "raw";
    doReset();
    @(negedge clk);
    exe_dest = 4'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    id_src1 = 4'd4; id_src_valid = 1'b1;
    step(1, 0, 0, 0, 1, 0);
    @(negedge clk); exe_mem_read = 1'b0; step(0, 0, 0, 0, 1, 0);
    @(negedge clk); exe_mem_read = 1'b1; id_src_valid = 1'b0; step(0, 0, 0, 0, 0, 0);
    @(negedge clk); id_two_src = 1'b1; id_src2 = 4'd4; id_src1 = 4'd3; step(1, 0, 0, 0, 1, 0);
    @(negedge clk);
    exe_dest = REG_PC; id_src1 = REG_PC; id_src_valid = 1'b1; id_two_src = 1'b0;
    step(1, 0, 0, 0, 1, 0);
    @(negedge clk); exe_wb_en = 1'b0; step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exe_mem_read = 1'b0; mem_dest = 4'd2; mem_wb_en = 1'b1;
    id_two_src = 1'b1; id_src2 = 4'd2; id_src1 = 4'd7; id_src_valid = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk); id_two_src = 1'b0; step(0, 0, 0, 0, 0, 0);
    @(negedge clk); id_src1 = 4'd2; step(0, 0, 0, 0, 1, 0);
    @(negedge clk); step(0, 0, 0, 0, 1, 0);

    // Continuous memory requests: MEM_WAIT=4 on A, MEM_WAIT=1 on C
    curTest = "memStream";
    doReset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_req = 1'b1;
      step(0, patA[11 - i], 0, !(i == 0 || i == 5 || i == 10), 0, (i % 2) == 0);
    end
    @(negedge clk);
    mem_req = 1'b0;
    pushExp("stallCntC", 8, 32'd6);
    step(0, 1, 0, 1, 0, 0);

    // Branch held during a freeze, with a load-use hazard pending
    curTest = "branch";
    doReset();
    @(negedge clk);
    exe_dest = 4'd4; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    id_src1 = 4'd4; id_src_valid = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
    step(1, 1, 0, 0, 1, 1);
    @(negedge clk); mem_req = 1'b0; step(1, 1, 0, 1, 1, 0);
    @(negedge clk); step(1, 1, 0, 1, 1, 0);
    @(negedge clk); step(1, 1, 0, 1, 1, 0);
    @(negedge clk); step(0, 0, 1, 1, 0, 0);
    @(negedge clk); branch_taken = 1'b0; step(1, 0, 0, 0, 1, 0);

    // Counter saturation
    curTest = "saturate";
    doReset();
    @(negedge clk);
    force dut_a.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut_a.stallCnt;
    cntA = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req = 1'b1;
      step(0, 1, 0, i != 0, 0, i != 1);
    end
    @(negedge clk); mem_req = 1'b0; step(0, 1, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
